buf_sched: RTL and testbench

BUF_SCHED -- requirements
Module: buf_sched

---
 rtl/buf_sched_pkg.sv | 25 ++
 rtl/buf_sched_id_fifo.sv | 50 +++++
 rtl/buf_sched.sv | 160 ++++++++++++++++
 tb/tb_buf_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/buf_sched_pkg.sv
// rtl/buf_sched_pkg.sv - buffer IDs, buffer-state encoding and helpers shared by buf_sched
package buf_sched_pkg;

    localparam logic [1:0] ID_NONE = 2'b00;
    localparam logic [1:0] ID_PING = 2'b01;
    localparam logic [1:0] ID_PANG = 2'b10;
    localparam logic [1:0] ID_PONG = 2'b11;

    localparam int NUM_BUFS = 3;

    typedef enum logic [2:0] {
        ST_EMPTY    = 3'd0,
        ST_SN       = 3'd1,
        ST_WAIT_CPU = 3'd2,
        ST_CPU      = 3'd3,
        ST_WAIT_FWD = 3'd4,
        ST_FWD      = 3'd5
    } buf_state_t;

    // Buffer index 0..2 maps onto IDs PING..PONG.
    function automatic logic [1:0] buf_id(input int idx);
        return 2'(idx + 1);
    endfunction

endpackage

// File: rtl/buf_sched_id_fifo.sv
// rtl/buf_sched_id_fifo.sv - 3-entry FIFO of 2-bit buffer IDs
module id_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [1:0] din_i,
    input  logic       pop_i,
    output logic [1:0] dout_o,
    output logic       empty_o,
    output logic       full_o
);

    logic [1:0] mem_q [3];
    logic [1:0] wr_q;
    logic [1:0] rd_q;
    logic [1:0] cnt_q;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    // Pointers and occupancy; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= 2'd0;
            rd_q  <= 2'd0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                wr_q <= nxt(wr_q);
            end
            if (pop_i) begin
                rd_q <= nxt(rd_q);
            end
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd3);

endmodule

// File: rtl/buf_sched.sv
// rtl/buf_sched.sv - ping/pang/pong ownership scheduler for snooper, filter CPU and forwarder
module buf_sched
    import buf_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] sn_sel,
    input  logic       sn_done,
    output logic [1:0] cpu_sel,
    input  logic       cpu_acc,
    input  logic       cpu_rej,
    output logic [1:0] fwd_sel,
    input  logic       fwd_done,
    output logic       full
);

    buf_state_t st_q [NUM_BUFS];
    buf_state_t st_d [NUM_BUFS];
    logic [1:0] sn_sel_q, sn_sel_d;
    logic [1:0] cpu_sel_q, cpu_sel_d;
    logic [1:0] fwd_sel_q, fwd_sel_d;
    logic       full_q, full_d;
    // Held low for the first edge after reset so the first grant lands on the second edge.
    logic       init_q;

    logic       pick_found;
    logic [1:0] pick_id;

    logic       cq_push, cq_pop, cq_empty, cq_full;
    logic [1:0] cq_head;
    logic       fq_push, fq_pop, fq_empty, fq_full;
    logic [1:0] fq_head;

    // Buffers handed from snooper to CPU, in snooper completion order.
    id_fifo u_cpu_q (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cq_push),
        .din_i   (sn_sel_q),
        .pop_i   (cq_pop),
        .dout_o  (cq_head),
        .empty_o (cq_empty),
        .full_o  (cq_full)
    );

    // Accepted buffers handed from CPU to forwarder, in acceptance order.
    id_fifo u_fwd_q (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fq_push),
        .din_i   (cpu_sel_q),
        .pop_i   (fq_pop),
        .dout_o  (fq_head),
        .empty_o (fq_empty),
        .full_o  (fq_full)
    );

    // Per-agent release/grant decisions and the resulting per-buffer next state.
    always_comb begin
        sn_sel_d   = sn_sel_q;
        cpu_sel_d  = cpu_sel_q;
        fwd_sel_d  = fwd_sel_q;
        cq_push    = 1'b0;
        cq_pop     = 1'b0;
        fq_push    = 1'b0;
        fq_pop     = 1'b0;
        pick_found = 1'b0;
        pick_id    = ID_NONE;
        full_d     = 1'b1;
        for (int b = 0; b < NUM_BUFS; b++) begin
            st_d[b] = st_q[b];
        end

        // Lowest-encoded EMPTY buffer, judged on registered state so a buffer
        // released this cycle is not reused until the next decision.
        for (int b = 0; b < NUM_BUFS; b++) begin
            if (!pick_found && st_q[b] == ST_EMPTY) begin
                pick_found = 1'b1;
                pick_id    = buf_id(b);
            end
        end

        if (sn_sel_q != ID_NONE) begin
            if (sn_done) begin
                cq_push  = 1'b1;
                sn_sel_d = ID_NONE;
            end
        end else if (init_q && pick_found) begin
            sn_sel_d = pick_id;
        end

        if (cpu_sel_q != ID_NONE) begin
            if (cpu_acc || cpu_rej) begin
                fq_push   = !cpu_rej;
                cpu_sel_d = ID_NONE;
            end
        end else if (!cq_empty) begin
            cq_pop    = 1'b1;
            cpu_sel_d = cq_head;
        end

        if (fwd_sel_q != ID_NONE) begin
            if (fwd_done) begin
                fwd_sel_d = ID_NONE;
            end
        end else if (!fq_empty) begin
            fq_pop    = 1'b1;
            fwd_sel_d = fq_head;
        end

        // Each agent touches a distinct buffer, so these updates never collide.
        for (int b = 0; b < NUM_BUFS; b++) begin
            if (sn_sel_q == buf_id(b) && sn_done)                   st_d[b] = ST_WAIT_CPU;
            if (sn_sel_q == ID_NONE && sn_sel_d == buf_id(b))       st_d[b] = ST_SN;
            if (cpu_sel_q == buf_id(b) && cpu_rej)                  st_d[b] = ST_EMPTY;
            else if (cpu_sel_q == buf_id(b) && cpu_acc)             st_d[b] = ST_WAIT_FWD;
            if (cq_pop && cq_head == buf_id(b))                     st_d[b] = ST_CPU;
            if (fwd_sel_q == buf_id(b) && fwd_done)                 st_d[b] = ST_EMPTY;
            if (fq_pop && fq_head == buf_id(b))                     st_d[b] = ST_FWD;
            if (st_d[b] == ST_EMPTY)                                full_d  = 1'b0;
        end
    end

    // Registered buffer states and grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BUFS; b++) begin
                st_q[b] <= ST_EMPTY;
            end
            sn_sel_q  <= ID_NONE;
            cpu_sel_q <= ID_NONE;
            fwd_sel_q <= ID_NONE;
            full_q    <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BUFS; b++) begin
                st_q[b] <= st_d[b];
            end
            sn_sel_q  <= sn_sel_d;
            cpu_sel_q <= cpu_sel_d;
            fwd_sel_q <= fwd_sel_d;
            full_q    <= full_d;
            init_q    <= 1'b1;
        end
    end

    assign sn_sel  = sn_sel_q;
    assign cpu_sel = cpu_sel_q;
    assign fwd_sel = fwd_sel_q;
    assign full    = full_q;

    a_cq_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(cq_push && cq_full));
    a_cq_no_underflow: assert property (@(posedge clk) disable iff (rst) !(cq_pop && cq_empty));
    a_fq_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(fq_push && fq_full));
    a_fq_no_underflow: assert property (@(posedge clk) disable iff (rst) !(fq_pop && fq_empty));
    a_sel_distinct:    assert property (@(posedge clk) disable iff (rst)
        !((sn_sel_q != ID_NONE && (sn_sel_q == cpu_sel_q || sn_sel_q == fwd_sel_q)) ||
          (cpu_sel_q != ID_NONE && cpu_sel_q == fwd_sel_q)));

endmodule

// File: tb/tb_buf_sched.sv
// tb/tb_buf_sched.sv - directed vector table plus randomised run against a queue-based model
module tb_buf_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       sn_done, cpu_acc, cpu_rej, fwd_done;
    logic [1:0] sn_sel, cpu_sel, fwd_sel;
    logic       full;

    always #5 clk = ~clk;

    buf_sched dut (
        .clk      (clk),
        .rst      (rst),
        .sn_sel   (sn_sel),
        .sn_done  (sn_done),
        .cpu_sel  (cpu_sel),
        .cpu_acc  (cpu_acc),
        .cpu_rej  (cpu_rej),
        .fwd_sel  (fwd_sel),
        .fwd_done (fwd_done),
        .full     (full)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: buffer states as small ints, hand-off queues as SV queues.
    localparam int E = 0, S = 1, WC = 2, C = 3, WF = 4, F = 5;
    int m_st [3];
    int m_sn, m_cpu, m_fwd, m_full, m_init;
    int cq [$];
    int fq [$];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_st[i] = E;
        m_sn = 0; m_cpu = 0; m_fwd = 0; m_full = 0; m_init = 0;
        cq.delete(); fq.delete();
    endtask

    task automatic model_step(input bit s, input bit a, input bit r, input bit f);
        int st [3];
        int nsn, ncpu, nfwd;
        for (int i = 0; i < 3; i++) st[i] = m_st[i];
        nsn = m_sn; ncpu = m_cpu; nfwd = m_fwd;
        if (m_sn != 0) begin
            if (s) begin st[m_sn-1] = WC; nsn = 0; end
        end else if (m_init != 0) begin
            for (int i = 2; i >= 0; i--) if (m_st[i] == E) nsn = i + 1;
            if (nsn != 0) st[nsn-1] = S;
        end
        if (m_cpu != 0) begin
            if (r)      begin st[m_cpu-1] = E;  ncpu = 0; end
            else if (a) begin st[m_cpu-1] = WF; ncpu = 0; end
        end else if (cq.size() > 0) begin
            ncpu = cq.pop_front(); st[ncpu-1] = C;
        end
        if (m_fwd != 0) begin
            if (f) begin st[m_fwd-1] = E; nfwd = 0; end
        end else if (fq.size() > 0) begin
            nfwd = fq.pop_front(); st[nfwd-1] = F;
        end
        if (m_sn != 0 && s) cq.push_back(m_sn);
        if (m_cpu != 0 && a && !r) fq.push_back(m_cpu);
        m_full = (st[0] != E && st[1] != E && st[2] != E) ? 1 : 0;
        for (int i = 0; i < 3; i++) m_st[i] = st[i];
        m_sn = nsn; m_cpu = ncpu; m_fwd = nfwd; m_init = 1;
    endtask

    // One clock: drive pulses, advance model at the edge, settle 1 time unit.
    task automatic cycle(input bit s, input bit a, input bit r, input bit f);
        sn_done = s; cpu_acc = a; cpu_rej = r; fwd_done = f;
        @(posedge clk);
        if (!rst) model_step(s, a, r, f);
        #1;
        sn_done = 0; cpu_acc = 0; cpu_rej = 0; fwd_done = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset sn_sel", sn_sel, 0);
        chk("reset cpu_sel", cpu_sel, 0);
        chk("reset fwd_sel", fwd_sel, 0);
        chk("reset full", full, 0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit s, a, r, f;
        int e_sn, e_cpu, e_fwd, e_full;
    } vec_t;

    vec_t tbl [$];
    int acc_log [$];
    int fwd_log [$];

    initial begin
        bit s, a, r, f;
        int prev_fwd, coll;
        int exp_sn [6];
        rst = 1'b1; sn_done = 0; cpu_acc = 0; cpu_rej = 0; fwd_done = 0;

        // Directed table, starting from reset release.
        tbl.push_back('{0,0,0,0, 0,0,0,0});   // first edge: no grant yet
        tbl.push_back('{0,0,0,0, 1,0,0,0});   // second edge: ping to snooper
        tbl.push_back('{0,0,0,0, 1,0,0,0});   // holds without pulses
        tbl.push_back('{1,0,0,0, 0,0,0,0});   // ping done
        tbl.push_back('{0,0,0,0, 2,1,0,0});   // pang to snooper, ping to CPU
        tbl.push_back('{1,0,0,0, 0,1,0,0});   // pang done
        tbl.push_back('{0,0,0,0, 3,1,0,1});   // pong granted, all owned
        tbl.push_back('{0,1,0,0, 3,0,0,1});   // CPU accepts ping
        tbl.push_back('{0,0,0,0, 3,2,1,1});   // pang to CPU, ping to forwarder
        tbl.push_back('{1,1,0,1, 0,0,0,0});   // triple simultaneous release
        tbl.push_back('{0,0,0,0, 1,3,2,1});   // all three regranted
        tbl.push_back('{0,1,1,0, 1,0,2,0});   // acc+rej on pong: rejected
        tbl.push_back('{0,0,0,1, 1,0,0,0});   // pang forwarded
        tbl.push_back('{0,0,0,0, 1,0,0,0});   // nothing queued
        tbl.push_back('{1,0,0,0, 0,0,0,0});   // ping done again
        tbl.push_back('{0,0,0,0, 2,1,0,0});   // lowest empty is pang
        tbl.push_back('{0,0,1,0, 2,0,0,0});   // CPU rejects ping
        tbl.push_back('{0,1,0,1, 2,0,0,0});   // pulses with sel=00 ignored
        tbl.push_back('{0,0,0,0, 2,0,0,0});

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].s, tbl[i].a, tbl[i].r, tbl[i].f);
            chk($sformatf("row%0d sn_sel", i), sn_sel, tbl[i].e_sn);
            chk($sformatf("row%0d cpu_sel", i), cpu_sel, tbl[i].e_cpu);
            chk($sformatf("row%0d fwd_sel", i), fwd_sel, tbl[i].e_fwd);
            chk($sformatf("row%0d full", i), full, tbl[i].e_full);
        end

        // Three snooper completions, then asynchronous reset with every buffer owned.
        do_reset();
        cycle(0,0,0,0);
        exp_sn = '{1, 0, 2, 0, 3, 0};
        for (int i = 0; i < 6; i++) begin
            cycle((i % 2) == 0 ? 1'b0 : 1'b1, 0, 0, 0);
            if (i == 0) cycle(1,0,0,0);
            else if (i < 5) ;
        end
        chk("triple sn_sel end", sn_sel, 0);
        chk("triple full", full, 1);
        chk("triple cpu_sel", cpu_sel, 1);
        do_reset();
        cycle(0,0,0,0);
        for (int i = 0; i < 6; i++) begin
            cycle((i % 2) == 1 ? 1'b1 : 1'b0, 0, 0, 0);
            chk($sformatf("seq%0d sn_sel", i), sn_sel, (i % 2) == 1 ? 0 : exp_sn[i]);
            if (i == 2) chk("cpu one cycle after first done", cpu_sel, 1);
        end
        chk("owned full", full, 1);
        rst = 1'b1;
        #2;
        chk("async rst sn_sel", sn_sel, 0);
        chk("async rst cpu_sel", cpu_sel, 0);
        chk("async rst fwd_sel", fwd_sel, 0);
        chk("async rst full", full, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(0,0,0,0);
        chk("restart edge1 sn_sel", sn_sel, 0);
        cycle(0,0,0,0);
        chk("restart edge2 sn_sel", sn_sel, 1);

        // Randomised run against the model.
        do_reset();
        prev_fwd = 0;
        for (int i = 0; i < 10000; i++) begin
            s = ($urandom_range(0, 1) == 0);
            a = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 1) == 0);
            if (a && !r && cpu_sel != 2'd0) acc_log.push_back(int'(cpu_sel));
            cycle(s, a, r, f);
            chk("rnd sn_sel", sn_sel, m_sn);
            chk("rnd cpu_sel", cpu_sel, m_cpu);
            chk("rnd fwd_sel", fwd_sel, m_fwd);
            chk("rnd full", full, m_full);
            coll = ((sn_sel != 0 && (sn_sel == cpu_sel || sn_sel == fwd_sel)) ||
                    (cpu_sel != 0 && cpu_sel == fwd_sel)) ? 1 : 0;
            chk("rnd sel distinct", coll, 0);
            if (prev_fwd == 0 && fwd_sel != 2'd0) fwd_log.push_back(int'(fwd_sel));
            prev_fwd = int'(fwd_sel);
        end
        chk("fwd count within accepted", (fwd_log.size() <= acc_log.size()) ? 1 : 0, 1);
        chk("accepted in flight bound", (acc_log.size() - fwd_log.size() <= 3) ? 1 : 0, 1);
        for (int i = 0; i < fwd_log.size() && i < acc_log.size(); i++) begin
            if (fwd_log[i] != acc_log[i])
                chk($sformatf("fwd order %0d", i), fwd_log[i], acc_log[i]);
        end
        chk("fwd order all", (fwd_log.size() > 0) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
